// File: rtl/dm_pkg.sv
// Shared byte-enable encodings and helpers for the word-organised data memory.
package dm_pkg;

  localparam int DM_DEPTH_DEFAULT = 1024;

  localparam logic [3:0] BET_WORD    = 4'b1111;
  localparam logic [3:0] BET_HALF_LO = 4'b0011;
  localparam logic [3:0] BET_HALF_HI = 4'b1100;
  localparam logic [3:0] BET_B0      = 4'b0001;
  localparam logic [3:0] BET_B1      = 4'b0010;
  localparam logic [3:0] BET_B2      = 4'b0100;
  localparam logic [3:0] BET_B3      = 4'b1000;

  typedef enum logic [1:0] {
    BET_CLASS_WORD    = 2'd0,
    BET_CLASS_HALF    = 2'd1,
    BET_CLASS_BYTE    = 2'd2,
    BET_CLASS_ILLEGAL = 2'd3
  } bet_class_e;

  function automatic bet_class_e bet_classify(input logic [3:0] bet);
    bet_class_e cls;
    case (bet)
      BET_WORD:                               cls = BET_CLASS_WORD;
      BET_HALF_LO, BET_HALF_HI:               cls = BET_CLASS_HALF;
      BET_B0, BET_B1, BET_B2, BET_B3:         cls = BET_CLASS_BYTE;
      default:                                cls = BET_CLASS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic bet_legal(input logic [3:0] bet);
    return (bet_classify(bet) != BET_CLASS_ILLEGAL);
  endfunction

  // Expand the 4 lane enables into a 32-bit bit mask.
  function automatic logic [31:0] bet_mask(input logic [3:0] bet);
    return {{8{bet[3]}}, {8{bet[2]}}, {8{bet[1]}}, {8{bet[0]}}};
  endfunction

endpackage

// File: rtl/dm_wreg.sv
// M/W stage boundary register for load data, low address bits and access status.
module dm_wreg
  import dm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] readdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        addr_err_i,
  output logic [31:0] readdata_o,
  output logic [1:0]  addr_lo_o,
  output logic        addr_err_o
);

  logic [31:0] readdata_q;
  logic [1:0]  addr_lo_q;
  logic        addr_err_q;

  // Free-running capture: no enable and no stall at this boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= 32'h0000_0000;
      addr_lo_q  <= 2'b00;
      addr_err_q <= 1'b0;
    end else begin
      readdata_q <= readdata_i;
      addr_lo_q  <= addr_lo_i;
      addr_err_q <= addr_err_i;
    end
  end

  assign readdata_o = readdata_q;
  assign addr_lo_o  = addr_lo_q;
  assign addr_err_o = addr_err_q;

endmodule

// File: rtl/dm_bytewise.sv
// Byte-enabled data memory for the M stage with combinational word reads.
// Optional address/enable checking is built when DM_ADDR_CHECK_EN is defined.
module dm_bytewise
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_DEFAULT,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] data_dm_M,
  input  logic [3:0]  bet,
  output logic [31:0] readdata_M,
  output logic [31:0] readdata_W,
  output logic [1:0]  addr_lo_W,
  output logic        addr_err_M,
  output logic        addr_err_W
);

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] index_s;
  logic              bet_ok_s;
  logic              store_en_s;
  logic [31:0]       word_s;
  logic [31:0]       lane_mask_s;
  logic [31:0]       merged_d;

  assign index_s     = addr_M[ADDR_W+1:2];
  assign bet_ok_s    = bet_legal(bet);
  assign lane_mask_s = bet_mask(bet);
  assign word_s      = mem_q[index_s];

`ifdef DM_ADDR_CHECK_EN
  logic oob_s;

  assign oob_s = (addr_M >= 32'(DEPTH_WORDS * 4));

  // Flag out-of-range accesses and malformed stores; flagged reads return zero.
  always_comb begin
    addr_err_M = 1'b0;
    readdata_M = word_s;
    if (oob_s) begin
      addr_err_M = 1'b1;
      readdata_M = 32'h0000_0000;
    end else if (memwrite_M && !bet_ok_s) begin
      addr_err_M = 1'b1;
    end else begin
      addr_err_M = 1'b0;
    end
  end

  assign store_en_s = memwrite_M & bet_ok_s & ~addr_err_M;
`else
  logic unused_addr_hi_s;

  // Upper address bits are dropped so the index wraps modulo the depth.
  assign unused_addr_hi_s = ^addr_M[31:ADDR_W+2];
  assign addr_err_M       = 1'b0;
  assign readdata_M       = word_s;
  assign store_en_s       = memwrite_M & bet_ok_s;
`endif

  assign merged_d = (word_s & ~lane_mask_s) | (data_dm_M & lane_mask_s);

  // Array update; reset wipes every word, including a store in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (store_en_s) begin
      mem_q[index_s] <= merged_d;
    end
  end

  dm_wreg u_wreg (
    .clk        (clk),
    .reset      (reset),
    .readdata_i (readdata_M),
    .addr_lo_i  (addr_M[1:0]),
    .addr_err_i (addr_err_M),
    .readdata_o (readdata_W),
    .addr_lo_o  (addr_lo_W),
    .addr_err_o (addr_err_W)
  );

endmodule

// File: tb/tb_dm_bytewise.sv
// Self-checking bench for dm_bytewise: directed plan steps plus random traffic
// against a word-array reference model.
module tb_dm_bytewise;

  localparam int DEPTH = 1024;
`ifdef DM_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite_M;
  logic [31:0] addr_M;
  logic [31:0] data_dm_M;
  logic [3:0]  bet;
  logic [31:0] readdata_M;
  logic [31:0] readdata_W;
  logic [1:0]  addr_lo_W;
  logic        addr_err_M;
  logic        addr_err_W;

  always #5 clk = ~clk;

  dm_bytewise dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite_M (memwrite_M),
    .addr_M     (addr_M),
    .data_dm_M  (data_dm_M),
    .bet        (bet),
    .readdata_M (readdata_M),
    .readdata_W (readdata_W),
    .addr_lo_W  (addr_lo_W),
    .addr_err_M (addr_err_M),
    .addr_err_W (addr_err_W)
  );

  logic [31:0] ref_mem [DEPTH];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [3:0] b);
    return b inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  function automatic bit ref_oob(input logic [31:0] a);
    return a >= 32'(DEPTH * 4);
  endfunction

  function automatic bit ref_err(input logic we, input logic [31:0] a, input logic [3:0] b);
    return CHK && (ref_oob(a) || (we && !ref_legal(b)));
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (CHK && ref_oob(a)) return 32'h0;
    return ref_mem[(a / 4) % DEPTH];
  endfunction

  task automatic ref_store(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b);
    int idx;
    logic [31:0] w;
    logic [31:0] m;
    if (we && ref_legal(b) && !ref_err(we, a, b)) begin
      idx = int'((a / 4) % DEPTH);
      w = ref_mem[idx];
      for (int k = 0; k < 4; k++) begin
        if (b[k]) begin
          m = 32'hFF << (8 * k);
          w = (w & ~m) | (d & m);
        end
      end
      ref_mem[idx] = w;
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  // One clock of traffic: check the M-side outputs before the edge, W-side after.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input string tag);
    logic [31:0] er;
    bit ee;
    memwrite_M = we; addr_M = a; data_dm_M = d; bet = b;
    #2;
    er = ref_read(a);
    ee = ref_err(we, a, b);
    check({tag, "/rdM"}, readdata_M, er);
    check({tag, "/errM"}, {31'b0, addr_err_M}, {31'b0, ee});
    @(posedge clk); #1;
    ref_store(we, a, d, b);
    check({tag, "/rdW"}, readdata_W, er);
    check({tag, "/loW"}, {30'b0, addr_lo_W}, {30'b0, a[1:0]});
    check({tag, "/errW"}, {31'b0, addr_err_W}, {31'b0, ee});
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp, input string tag);
    memwrite_M = 1'b0; addr_M = a; bet = 4'b0000;
    #1;
    check(tag, readdata_M, exp);
  endtask

  logic [3:0] legal_tab [7];

  initial begin
    logic [31:0] a;
    logic [3:0]  b;
    legal_tab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    reset = 1'b1; memwrite_M = 1'b0; addr_M = 32'h0; data_dm_M = 32'h0; bet = 4'b0000;
    ref_clear();
    @(posedge clk); @(posedge clk); #1;
    check("rst/rdW", readdata_W, 32'h0);
    check("rst/loW", {30'b0, addr_lo_W}, 32'h0);
    check("rst/errW", {31'b0, addr_err_W}, 32'h0);
    reset = 1'b0;

    cycle(1'b0, 32'h0000_0000, 32'h0, 4'b0000, "rd0");
    cycle(1'b0, 32'h0000_0004, 32'h0, 4'b0000, "rd4");
    cycle(1'b0, 32'h0000_0FFC, 32'h0, 4'b0000, "rdFFC");
    peek(32'h0000_0FFC, 32'h0, "rdFFC/const");

    cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, "stw");
    cycle(1'b0, 32'h0000_0010, 32'h0, 4'b0000, "ldw");
    check("ldw/constW", readdata_W, 32'hDEAD_BEEF);

    cycle(1'b1, 32'h0000_0010, 32'h0000_00AA, 4'b0001, "stb0");
    cycle(1'b1, 32'h0000_0013, 32'h5500_0000, 4'b1000, "stb3");
    peek(32'h0000_0010, 32'h55AD_BEAA, "bytes/const");

    cycle(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, "rebase");
    cycle(1'b1, 32'h0000_0012, 32'h1234_0000, 4'b1100, "sthhi");
    peek(32'h0000_0012, 32'h1234_BEEF, "half/const");

    cycle(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0101, "illbet");
    peek(32'h0000_0010, 32'h1234_BEEF, "illbet/const");

    // Reset asserted while a second store to 0x20 is on the bus.
    cycle(1'b1, 32'h0000_0020, 32'h1111_1111, 4'b1111, "st20a");
    memwrite_M = 1'b1; addr_M = 32'h0000_0023; data_dm_M = 32'h2222_2222; bet = 4'b1111;
    #2;
    reset = 1'b1;
    ref_clear();
    @(posedge clk); #1;
    check("midrst/rdW", readdata_W, 32'h0);
    check("midrst/loW", {30'b0, addr_lo_W}, 32'h0);
    check("midrst/errW", {31'b0, addr_err_W}, 32'h0);
    check("midrst/rdM", readdata_M, 32'h0);
    memwrite_M = 1'b0;
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    cycle(1'b0, 32'h0000_0020, 32'h0, 4'b0000, "post/rd20");
    cycle(1'b1, 32'h0000_1020, 32'h3333_3333, 4'b1111, "st1020");
    peek(32'h0000_0020, CHK ? 32'h0 : 32'h3333_3333, "alias/const");

    // Random traffic over a small window with occasional aliasing/out-of-range addresses.
    for (int n = 0; n < 300; n++) begin
      a = {22'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'b0} >> 2;
      a = {a[29:0], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 12);
      if ($urandom_range(0, 3) == 0) b = 4'($urandom_range(0, 15));
      else                           b = legal_tab[$urandom_range(0, 6)];
      cycle(1'($urandom_range(0, 1)), a, $urandom, b, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
